// File: rtl/iterative_alu_if.sv
// Handshake and operand bundle between the operand muxes and the
// iterative execute ALU.
interface iterative_alu_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [3:0]      control_line_i;
  logic [XLEN-1:0] operand_a_i;
  logic [XLEN-1:0] operand_b_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;
  logic            zero_o;

  modport master (
    output start_i,
    output control_line_i,
    output operand_a_i,
    output operand_b_i,
    input  busy_o,
    input  done_o,
    input  result_o,
    input  zero_o
  );

  modport slave (
    input  start_i,
    input  control_line_i,
    input  operand_a_i,
    input  operand_b_i,
    output busy_o,
    output done_o,
    output result_o,
    output zero_o
  );
endinterface

// File: rtl/iterative_alu.sv
// Execute-stage ALU: logic/add/sub in one cycle, shifts serially
// one bit per clock with a start/done handshake.
module iterative_alu #(
  parameter int XLEN = 32
) (
  input logic           clk_i,
  input logic           rst_ni,
  iterative_alu_if.slave alu
);
  localparam int SHAMT_W = $clog2(XLEN);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0]    acc_q, acc_d;
  logic [XLEN-1:0]    res_q, res_d;
  logic [XLEN-1:0]    acc_sh;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [SHAMT_W-1:0] shamt;
  logic               dir_q, dir_d;
  logic               done_q, done_d;
  logic               unused_b;

  assign shamt    = alu.operand_b_i[SHAMT_W-1:0];
  assign unused_b = ^alu.operand_b_i[XLEN-1:SHAMT_W];

  // One-bit step of the serial shifter; dir_q = 1 means logical right.
  assign acc_sh = dir_q ? (acc_q >> 1) : (acc_q << 1);

  // Next-state, datapath and completion decode.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    res_d   = res_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (alu.start_i) begin
          done_d = 1'b1;
          unique case (alu.control_line_i)
            OP_AND: res_d = alu.operand_a_i & alu.operand_b_i;
            OP_OR:  res_d = alu.operand_a_i | alu.operand_b_i;
            OP_XOR: res_d = alu.operand_a_i ^ alu.operand_b_i;
            OP_ADD: res_d = alu.operand_a_i + alu.operand_b_i;
            OP_SUB: res_d = alu.operand_a_i - alu.operand_b_i;
            OP_SLL, OP_SRL: begin
              if (shamt == '0) begin
                res_d = alu.operand_a_i;
              end else begin
                done_d  = 1'b0;
                acc_d   = alu.operand_a_i;
                cnt_d   = shamt;
                dir_d   = (alu.control_line_i == OP_SRL);
                state_d = SHIFT;
              end
            end
            default: res_d = '0;
          endcase
        end
      end
      SHIFT: begin
        acc_d = acc_sh;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) begin
          res_d   = acc_sh;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any shift in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      res_q   <= res_d;
      done_q  <= done_d;
    end
  end

  assign alu.result_o = res_q;
  assign alu.done_o   = done_q;
  assign alu.busy_o   = (state_q == SHIFT);
  assign alu.zero_o   = (res_q == '0);
endmodule

// File: tb/tb_iterative_alu.sv
// Randomized and directed bench for iterative_alu against a
// cycle-indexed behavioural model.
module tb_iterative_alu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  iterative_alu_if #(.XLEN(32)) bus ();

  iterative_alu #(.XLEN(32)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .alu   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_op(input logic [3:0] c,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0011: return a ^ b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0100: return a << b[4:0];
      4'b0101: return a >> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] c,
                                 input logic [31:0] b);
    if (c == 4'b0100 || c == 4'b0101) return int'(b[4:0]);
    return 0;
  endfunction

  // Model: ecount = rising edges seen; a request accepted at edge E
  // completes (done visible) after edge E+k, busy after E..E+k-1.
  int          ecount = 0;
  int          done_edge = -1;
  logic [31:0] m_res = '0;
  logic [31:0] pending = '0;

  // Check outputs against the model, then predict the next edge.
  always @(negedge clk) begin
    bit busy_now;
    if (!rst_n) begin
      done_edge = -1;
      m_res = '0;
      chk("rst_done", 32'(bus.done_o), 32'(0));
      chk("rst_busy", 32'(bus.busy_o), 32'(0));
      chk("rst_result", bus.result_o, 32'h0);
      chk("rst_zero", 32'(bus.zero_o), 32'(1));
      ecount++;
    end else begin
      busy_now = (done_edge > ecount);
      chk("done", 32'(bus.done_o), 32'(done_edge == ecount));
      chk("busy", 32'(bus.busy_o), 32'(busy_now));
      chk("result", bus.result_o, m_res);
      chk("zero", 32'(bus.zero_o), 32'(m_res == 0));
      ecount++;
      if (bus.start_i && !busy_now) begin
        pending = ref_op(bus.control_line_i, bus.operand_a_i,
                         bus.operand_b_i);
        done_edge = ecount + ref_lat(bus.control_line_i,
                                     bus.operand_b_i);
      end
      if (done_edge == ecount) m_res = pending;
    end
  end

  task automatic drive_idle();
    bus.start_i = 1'b0;
    bus.control_line_i = 4'($urandom);
    bus.operand_a_i = $urandom;
    bus.operand_b_i = $urandom;
  endtask

  task automatic run_op(input string nm, input logic [3:0] c,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input int exp_lat,
                        output int nbusy);
    bit seen = 0;
    int lat = 0;
    nbusy = 0;
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.control_line_i = c;
    bus.operand_a_i = a;
    bus.operand_b_i = b;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      if (bus.busy_o) nbusy++;
      if (bus.done_o) begin
        seen = 1;
        lat = i;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no done expected done", nm);
    end else begin
      chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({nm, "_res"}, bus.result_o, exp_r);
    end
  endtask

  logic [3:0]  b2b_c[5] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
  logic [31:0] b2b_a[5] = '{32'hF0, 32'hF0, 32'hF0, 32'hFFFF_FFFF, 32'h0};
  logic [31:0] b2b_b[5] = '{32'hF0F, 32'hF0F, 32'hF0F, 32'h1, 32'h1};
  logic [31:0] b2b_r[5] = '{32'h0, 32'hFFF, 32'hFFF, 32'h0, 32'hFFFF_FFFF};
  logic [3:0]  codes[7] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010,
                           4'b0110, 4'b0100, 4'b0101};

  initial begin
    int nb;
    int ndone;
    logic [31:0] dres;
    drive_idle();

    // Reset held with random inputs, including start requests.
    repeat (4) begin
      @(posedge clk); #1;
      drive_idle();
      bus.start_i = 1'($urandom);
    end
    chk("hold_rst_result", bus.result_o, 32'h0);
    chk("hold_rst_zero", 32'(bus.zero_o), 32'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive_idle();

    // Back-to-back single-cycle operations.
    for (int i = 0; i <= 5; i++) begin
      @(posedge clk); #1;
      if (i < 5) begin
        bus.start_i = 1'b1;
        bus.control_line_i = b2b_c[i];
        bus.operand_a_i = b2b_a[i];
        bus.operand_b_i = b2b_b[i];
      end else begin
        drive_idle();
      end
      if (i > 0) begin
        @(negedge clk);
        chk("b2b_done", 32'(bus.done_o), 32'(1));
        chk("b2b_res", bus.result_o, b2b_r[i-1]);
        chk("b2b_zero", 32'(bus.zero_o), 32'(b2b_r[i-1] == 0));
      end
    end

    run_op("sll31", 4'b0100, 32'h1, 32'd31, 32'h8000_0000, 32, nb);
    chk("sll31_busy", 32'(nb), 32'(31));
    run_op("srl4", 4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 5, nb);
    chk("srl4_busy", 32'(nb), 32'(4));
    run_op("sll0", 4'b0100, 32'h1234_5678, 32'h20, 32'h1234_5678, 1, nb);
    chk("sll0_busy", 32'(nb), 32'(0));
    run_op("undef", 4'b1111, 32'hDEAD_BEEF, 32'h5, 32'h0, 1, nb);
    chk("undef_zero", 32'(bus.zero_o), 32'(1));

    // Start during a serial shift is dropped.
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.control_line_i = 4'b0101;
    bus.operand_a_i = 32'hF000_0000;
    bus.operand_b_i = 32'd8;
    @(posedge clk); #1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    bus.start_i = 1'b1;
    bus.control_line_i = 4'b0010;
    bus.operand_a_i = 32'h1;
    bus.operand_b_i = 32'h1;
    @(posedge clk); #1;
    drive_idle();
    ndone = 0;
    dres = '0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done_o) begin
        ndone++;
        dres = bus.result_o;
      end
    end
    chk("coll_ndone", 32'(ndone), 32'(1));
    chk("coll_res", dres, 32'h00F0_0000);

    // Asynchronous reset in the middle of a shift.
    run_op("xor_pre", 4'b0011, 32'hFF, 32'h0F, 32'hF0, 1, nb);
    @(posedge clk); #1;
    bus.start_i = 1'b1;
    bus.control_line_i = 4'b0100;
    bus.operand_a_i = 32'h1;
    bus.operand_b_i = 32'd20;
    @(posedge clk); #1;
    drive_idle();
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", 32'(bus.busy_o), 32'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_result", bus.result_o, 32'h0);
    chk("async_done", 32'(bus.done_o), 32'(0));
    chk("async_busy", 32'(bus.busy_o), 32'(0));
    chk("async_zero", 32'(bus.zero_o), 32'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op("add_post", 4'b0010, 32'd2, 32'd3, 32'd5, 1, nb);

    // Random traffic; the negedge model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      drive_idle();
      bus.start_i = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0)
        bus.control_line_i = 4'($urandom);
      else
        bus.control_line_i = codes[$urandom_range(0, 6)];
      case ($urandom_range(0, 5))
        0: bus.operand_a_i = 32'h0;
        1: bus.operand_a_i = 32'hFFFF_FFFF;
        default: ;
      endcase
      if ($urandom_range(0, 1) == 0)
        bus.operand_b_i = 32'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    drive_idle();
    repeat (40) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/iterative_alu.md
# iterative_alu

Multi-cycle execute-stage ALU that consumes the 4-bit ALU control code produced by the ALU control decoder and computes a registered result with a start/done handshake. AND, OR, XOR, ADD and SUB complete in one cycle. SLL and SRL run serially, one bit position per clock, to keep the barrel shifter out of the datapath. It sits between the ALU control decoder / register-file operand muxes and the writeback/branch logic.

## Interface

- XLEN, 32, operand and result width; shift amount width SHAMT_W = $clog2(XLEN) (5 at default).
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  asynchronous, active-low reset.
- start_i  input  1  request; accepted only in a cycle where busy_o = 0.
- control_line_i  input  4  operation code: 0000 AND, 0001 OR, 0011 XOR, 0010 ADD, 0110 SUB, 0100 SLL, 0101 SRL.
- operand_a_i  input  XLEN  first operand; the value shifted for SLL/SRL.
- operand_b_i  input  XLEN  second operand; bits [SHAMT_W-1:0] are the shift amount for SLL/SRL.
- busy_o  output  1  high while a serial shift is in progress.
- done_o  output  1  single-cycle pulse; result_o is valid and updated in this cycle.
- result_o  output  XLEN  last completed result; held until the next completion.
- zero_o  output  1  high when result_o == 0; combinational from result_o.

## Operation

- States: IDLE and SHIFT. Internal registers: state, acc (XLEN), cnt (SHAMT_W), op (latched shift direction), result_o, done_o.
- Reset (async, rst_ni = 0):
  - state = IDLE, acc = 0, cnt = 0, result_o = 0, done_o = 0, busy_o = 0.
  - zero_o = 1 as a consequence of result_o = 0.
- IDLE, start_i = 1, code in {AND, OR, XOR, ADD, SUB}:
  - result_o <= f(a, b); done_o <= 1; stay IDLE.
  - ADD and SUB wrap modulo 2^XLEN; carry and borrow are discarded.
- IDLE, start_i = 1, code SLL/SRL, shamt = 0: result_o <= operand_a_i; done_o <= 1; stay IDLE.
- IDLE, start_i = 1, code SLL/SRL, shamt = k > 0:
  - acc <= operand_a_i; cnt <= k; latch direction; done_o <= 0; state <= SHIFT.
- SHIFT, each cycle:
  - acc shifts by 1: SLL shifts left with zero-fill; SRL shifts right logically with zero-fill.
  - cnt decrements.
  - When cnt == 1: result_o <= shifted acc; done_o <= 1; state <= IDLE.
- Undefined control code with start_i = 1: result_o <= 0; done_o <= 1; latency 1.
- IDLE with start_i = 0: done_o <= 0; result_o holds.
- start_i while busy_o = 1 is ignored and not queued.
- All operand and control inputs are don't-care during SHIFT because their values were latched at acceptance.
- busy_o = (state == SHIFT).

## Timing

- Request accepted in cycle N:
  - single-cycle ops, undefined codes and shamt 0: done_o and the new result_o appear in cycle N+1.
  - shifts with shamt k > 0: done_o and the new result_o appear in cycle N+1+k; busy_o is high in cycles N+1 through N+k.
- Maximum latency is 32 cycles (k = 31).
- Back-to-back operation: a new start_i may be accepted in the same cycle done_o is high, because busy_o = 0 in that cycle. Single-cycle ops therefore sustain one result per clock.
- done_o is high for exactly one cycle per accepted request and never without one.
- Reset asserted mid-shift aborts the operation immediately: no done_o, and result_o returns to 0.
- Reset deassertion takes effect on the next rising edge. The first start_i can be accepted in the cycle after release.

## Test plan

- Reset: hold rst_ni = 0 with random inputs -> result_o = 0, zero_o = 1, busy_o = 0, done_o = 0. Then assert rst_ni low asynchronously mid-cycle -> outputs clear without waiting for a clock edge.
- Single-cycle ops, back-to-back starts in consecutive cycles:
  - a = 0x0000_00F0, b = 0x0000_0F0F -> AND 0x0000_0000 (zero_o = 1), OR 0x0000_0FFF, XOR 0x0000_0FFF.
  - ADD 0xFFFF_FFFF + 1 -> 0x0000_0000, zero_o = 1.
  - SUB 0 - 1 -> 0xFFFF_FFFF.
  - Each result arrives one cycle after its start, with done_o high every cycle.
- SLL a = 0x0000_0001, b = 31 -> busy_o high for 31 cycles, done_o in cycle N+32, result 0x8000_0000. SRL a = 0x8000_0000, b = 4 -> done_o in cycle N+5, result 0x0800_0000.
- Shift amount 0 and upper bits of b: SLL a = 0x1234_5678, b = 0x0000_0020 (shamt = 0) -> done_o in cycle N+1, result 0x1234_5678, busy_o never high.
- Busy collision and undefined code:
  - pulse start_i with ADD during an SRL (b = 8) -> ADD ignored, only the SRL completes, exactly one done_o.
  - code 1111 -> result 0, zero_o = 1, done_o in cycle N+1.
- Reset mid-shift: SLL b = 20, assert rst_ni low at cycle N+5 -> no done_o, result_o = 0. After release, a new ADD 2 + 3 -> 5 in 1 cycle.
